// File: rtl/fnd_pkg.sv
// Shared definitions for the FND display path: segment font, converter states
// and the BCD register sizing helper.
package fnd_pkg;

    // Segment codes are {dp,g,f,e,d,c,b,a}, active-low.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } conv_state_e;

    // Decimal digits needed for 2**bin_w-1, widened to at least `digits`, in bits.
    function automatic int bcd_width(input int bin_w, input int digits);
        longint unsigned maxv;
        longint unsigned p;
        int              nd;
        maxv = (longint'(1) << bin_w) - 1;
        p    = 10;
        nd   = 1;
        for (int i = 0; i < 10; i++) begin
            if (p <= maxv) begin
                nd = nd + 1;
                p  = p * 10;
            end
        end
        if (nd < digits) nd = digits;
        return 4 * nd;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [7:0] seg_font(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter with valid/ready input and a
// one-cycle load strobe carrying the low DIGITS nibbles and the overflow flag.
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [BIN_W-1:0]      i_value,
    output logic                  o_ready,
    output logic                  o_load,
    output logic [DIGITS*4-1:0]   o_bcd,
    output logic                  o_overflow
);

    localparam int              BCD_W = bcd_width(BIN_W, DIGITS);
    localparam int              CNT_W = $clog2(BIN_W + 1);
    localparam longint unsigned LIMIT = pow10(DIGITS);

    conv_state_e        state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_adj;
    logic [BIN_W-1:0]   bin_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_load  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (cnt_q == CNT_W'(BIN_W - 1)) state_d = LOAD;
            end
            LOAD: begin
                o_load  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Correct every nibble before the shift so it carries properly into the next.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < BCD_W / 4; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q <= '0;
            bin_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            bcd_q <= '0;
            bin_q <= i_value;
            cnt_q <= '0;
            ovf_q <= (64'(i_value) >= LIMIT);
        end else if (state_q == CONV) begin
            {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
            cnt_q          <= cnt_q + 1'b1;
        end
    end

    assign o_bcd      = bcd_q[DIGITS*4-1:0];
    assign o_overflow = ovf_q;

endmodule

// File: rtl/fnd_bin_display.sv
// Multi-digit seven-segment controller: binary in, BCD display register, scan
// divider and font mux. Define FND_LZ_BLANK_EN to blank leading zeros.
module fnd_bin_display
    import fnd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000,
    parameter int DIGITS  = 4,
    parameter int BIN_W   = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [BIN_W-1:0]  i_value,
    output logic              o_ready,
    output logic              o_overflow,
    output logic [DIGITS-1:0] fndCom,
    output logic [7:0]        fndFont
);

    localparam int DIV_TC = CLK_HZ / SCAN_HZ - 1;
    localparam int DIV_W  = $clog2(DIV_TC + 1);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                   conv_load;
    logic [DIGITS*4-1:0]    conv_bcd;
    logic                   conv_ovf;

    logic [DIGITS-1:0][3:0] disp_bcd;
    logic                   disp_ovf;
    logic [DIV_W-1:0]       div_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   tick;
    logic [DIGITS-1:0]      blank_mask;
    logic [3:0]             cur_nib;

    bin2bcd_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_conv (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_value    (i_value),
        .o_ready    (o_ready),
        .o_load     (conv_load),
        .o_bcd      (conv_bcd),
        .o_overflow (conv_ovf)
    );

    // Digits and overflow land together so a half-updated value is never shown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else if (conv_load) begin
            disp_bcd <= conv_bcd;
            disp_ovf <= conv_ovf;
        end
    end

    assign tick = (div_q == DIV_W'(DIV_TC));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

`ifdef FND_LZ_BLANK_EN
    // Walk down from the top digit; blank while everything above is still zero.
    always_comb begin
        logic run;
        run        = 1'b1;
        blank_mask = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            run           = run && (disp_bcd[d] == 4'd0);
            blank_mask[d] = run && (d != 0);
        end
    end
`else
    assign blank_mask = '0;
`endif

    assign cur_nib = disp_bcd[idx_q];
    assign fndCom  = ~(DIGITS'(1) << idx_q);

    always_comb begin
        fndFont = seg_font(cur_nib);
        if (disp_ovf)                fndFont = SEG_DASH;
        else if (blank_mask[idx_q])  fndFont = SEG_BLANK;
    end

    assign o_overflow = disp_ovf;

endmodule

// File: tb/tb_fnd_bin_display.sv
// Randomised self-checking bench for fnd_bin_display against a decimal-arithmetic
// reference of what each digit should show.
module tb_fnd_bin_display;

    localparam int DIGITS  = 4;
    localparam int BIN_W   = 14;
    localparam int CLK_HZ  = 1000;
    localparam int SCAN_HZ = 100;
    localparam int STEP    = CLK_HZ / SCAN_HZ;
    localparam int LIMIT   = 10 ** DIGITS;
    localparam int MAXV    = (1 << BIN_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_valid = 1'b0;
    logic [BIN_W-1:0]  i_value = '0;
    logic              o_ready;
    logic              o_overflow;
    logic [DIGITS-1:0] fndCom;
    logic [7:0]        fndFont;

    int tests_run = 0;
    int fails = 0;
    int unsigned ecnt;

    logic [7:0] font_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    fnd_bin_display #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ),
        .DIGITS  (DIGITS),
        .BIN_W   (BIN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_value    (i_value),
        .o_ready    (o_ready),
        .o_overflow (o_overflow),
        .fndCom     (fndCom),
        .fndFont    (fndFont)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset was last released; drives the scan expectation.
    always @(posedge clk or negedge reset) begin
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    function automatic logic [7:0] exp_font(input int v, input int d);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (v >= LIMIT) return 8'hBF;
`ifdef FND_LZ_BLANK_EN
        if (d > 0 && v < p) return 8'hFF;
`endif
        return font_tbl[(v / p) % 10];
    endfunction

    function automatic logic [DIGITS-1:0] exp_com(input int unsigned n);
        logic [DIGITS-1:0] one;
        one = 1;
        return ~(one << ((n / STEP) % DIGITS));
    endfunction

    function automatic int cur_digit();
        logic [DIGITS-1:0] one;
        one = 1;
        for (int d = 0; d < DIGITS; d++)
            if (fndCom === ~(one << d)) return d;
        return -1;
    endfunction

    // Observation only: records the font seen for each digit over one full frame.
    task automatic capture_frame(output logic [DIGITS-1:0][7:0] seen);
        int d;
        seen = 'x;
        repeat (STEP * DIGITS + 2) begin
            @(negedge clk);
            d = cur_digit();
            if (d >= 0) seen[d] = fndFont;
        end
    endtask

    task automatic accept(input int v, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        i_valid = 1'b1;
        i_value = BIN_W'(v);
        while (o_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (o_ready === 1'b1);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_done(output int lowcnt);
        lowcnt = 0;
        while (o_ready !== 1'b1 && lowcnt < 200) begin
            lowcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [DIGITS-1:0][7:0] seen;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (fndCom !== 4'hE || fndFont !== 8'hC0) begin
            fails++;
            $display("FAIL reset_outputs: com=%h font=%h expected com=e font=c0", fndCom, fndFont);
        end
        tests_run++;
        if (o_ready !== 1'b1 || o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: ready=%b ovf=%b expected ready=1 ovf=0", o_ready, o_overflow);
        end
        reset = 1'b1;
        capture_frame(seen);
        for (int d = 0; d < DIGITS; d++) begin
            tests_run++;
            if (seen[d] !== exp_font(0, d)) begin
                fails++;
                $display("FAIL reset_digit%0d: got %h expected %h", d, seen[d], exp_font(0, d));
            end
        end
    endtask

    task automatic test_scan();
        int bad;
        bad = 0;
        for (int i = 0; i < STEP * DIGITS * 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (fndCom !== exp_com(ecnt)) begin
                fails++;
                bad++;
                if (bad < 5)
                    $display("FAIL scan_com at edge %0d: got %h expected %h", ecnt, fndCom, exp_com(ecnt));
            end
        end
    endtask

    task automatic test_convert();
        int vals [4] = '{1234, 9999, 0, MAXV};
        bit ok;
        int lowcnt;
        logic [DIGITS-1:0][7:0] seen;
        foreach (vals[k]) begin
            accept(vals[k], ok);
            wait_done(lowcnt);
            tests_run++;
            if (!ok || lowcnt != BIN_W + 1) begin
                fails++;
                $display("FAIL convert_busy(%0d): ok=%b busy=%0d expected busy=%0d", vals[k], ok, lowcnt, BIN_W + 1);
            end
            tests_run++;
            if (o_overflow !== (vals[k] >= LIMIT)) begin
                fails++;
                $display("FAIL convert_ovf(%0d): got %b expected %b", vals[k], o_overflow, vals[k] >= LIMIT);
            end
            capture_frame(seen);
            for (int d = 0; d < DIGITS; d++) begin
                tests_run++;
                if (seen[d] !== exp_font(vals[k], d)) begin
                    fails++;
                    $display("FAIL convert(%0d)_digit%0d: got %h expected %h", vals[k], d, seen[d], exp_font(vals[k], d));
                end
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int lowcnt;
        logic [DIGITS-1:0][7:0] seen;
        accept(LIMIT, ok);
        wait_done(lowcnt);
        tests_run++;
        if (!ok || o_overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_set: ok=%b ovf=%b expected 1", ok, o_overflow);
        end
        capture_frame(seen);
        for (int d = 0; d < DIGITS; d++) begin
            tests_run++;
            if (seen[d] !== 8'hBF) begin
                fails++;
                $display("FAIL overflow_dash_digit%0d: got %h expected bf", d, seen[d]);
            end
        end
        accept(5, ok);
        wait_done(lowcnt);
        tests_run++;
        if (!ok || o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_clear: ok=%b ovf=%b expected 0", ok, o_overflow);
        end
        capture_frame(seen);
        for (int d = 0; d < DIGITS; d++) begin
            tests_run++;
            if (seen[d] !== exp_font(5, d)) begin
                fails++;
                $display("FAIL overflow_after5_digit%0d: got %h expected %h", d, seen[d], exp_font(5, d));
            end
        end
    endtask

    task automatic test_leading_zero();
        bit ok;
        int lowcnt;
        logic [DIGITS-1:0][7:0] seen;
        accept(7, ok);
        wait_done(lowcnt);
        capture_frame(seen);
        for (int d = 0; d < DIGITS; d++) begin
            tests_run++;
            if (!ok || seen[d] !== exp_font(7, d)) begin
                fails++;
                $display("FAIL lz7_digit%0d: ok=%b got %h expected %h", d, ok, seen[d], exp_font(7, d));
            end
        end
    endtask

    task automatic test_back_to_back();
        int lowcnt;
        int d;
        logic [DIGITS-1:0][7:0] seen;
        @(negedge clk);
        i_valid = 1'b1;
        i_value = BIN_W'(4321);
        @(posedge clk);
        @(negedge clk);
        i_value = BIN_W'(8765);
        wait_done(lowcnt);
        tests_run++;
        if (lowcnt != BIN_W + 1) begin
            fails++;
            $display("FAIL hold_busy1: busy=%0d expected %0d", lowcnt, BIN_W + 1);
        end
        d = cur_digit();
        tests_run++;
        if (d < 0 || fndFont !== exp_font(4321, d)) begin
            fails++;
            $display("FAIL hold_first_value digit%0d: got %h expected %h", d, fndFont, exp_font(4321, (d < 0) ? 0 : d));
        end
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        wait_done(lowcnt);
        tests_run++;
        if (lowcnt != BIN_W + 1) begin
            fails++;
            $display("FAIL hold_busy2: busy=%0d expected %0d", lowcnt, BIN_W + 1);
        end
        capture_frame(seen);
        for (int k = 0; k < DIGITS; k++) begin
            tests_run++;
            if (seen[k] !== exp_font(8765, k)) begin
                fails++;
                $display("FAIL hold_second_digit%0d: got %h expected %h", k, seen[k], exp_font(8765, k));
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int lowcnt;
        int v;
        logic [DIGITS-1:0][7:0] seen;
        for (int n = 0; n < 12; n++) begin
            v = int'($urandom_range(0, MAXV));
            accept(v, ok);
            wait_done(lowcnt);
            tests_run++;
            if (!ok || lowcnt != BIN_W + 1 || o_overflow !== (v >= LIMIT)) begin
                fails++;
                $display("FAIL random(%0d)_status: ok=%b busy=%0d ovf=%b expected busy=%0d ovf=%b",
                         v, ok, lowcnt, o_overflow, BIN_W + 1, v >= LIMIT);
            end
            capture_frame(seen);
            for (int d = 0; d < DIGITS; d++) begin
                tests_run++;
                if (seen[d] !== exp_font(v, d)) begin
                    fails++;
                    $display("FAIL random(%0d)_digit%0d: got %h expected %h", v, d, seen[d], exp_font(v, d));
                end
            end
        end
        // Leave a non-zero value showing so the reset test sees it cleared.
        accept(8888, ok);
        wait_done(lowcnt);
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [DIGITS-1:0][7:0] seen;
        accept(9999, ok);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (fndCom !== 4'hE || fndFont !== 8'hC0 || o_ready !== 1'b1 || o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: com=%h font=%h ready=%b ovf=%b expected e c0 1 0",
                     fndCom, fndFont, o_ready, o_overflow);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3 * STEP) @(negedge clk);
        capture_frame(seen);
        for (int d = 0; d < DIGITS; d++) begin
            tests_run++;
            if (seen[d] !== exp_font(0, d)) begin
                fails++;
                $display("FAIL reset_mid_digit%0d: got %h expected %h", d, seen[d], exp_font(0, d));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_convert();
        test_overflow();
        test_leading_zero();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
